// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS control sequencer with ALU control decode and retire counter
module mips_mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [3:0]  ALUCtrl,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic [1:0]  PCSource,
    output logic        pc_we,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;
    logic        mem_rdy;

    // Memory handshake is masked while reset is held so no enable can fire during reset.
    assign mem_rdy = mem_ready & rst_n;
    assign retired = retired_q;

    // State and retire counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and per-state control decode; all controls default to 0.
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        ALUCtrl  = ALU_AND;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        PCSource = 2'b00;
        pc_we    = 1'b0;
        illegal  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUCtrl = ALU_ADD;
                IRWrite = mem_rdy;
                pc_we   = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                ALUSrcB = 2'b11;
                ALUCtrl = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_IEXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUCtrl = ALU_ADD;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_rdy) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                state_d = S_RWB;
                case (funct)
                    6'h20:   ALUCtrl = ALU_ADD;
                    6'h22:   ALUCtrl = ALU_SUB;
                    6'h24:   ALUCtrl = ALU_AND;
                    6'h25:   ALUCtrl = ALU_OR;
                    6'h2A:   ALUCtrl = ALU_SLT;
                    6'h00:   ALUCtrl = ALU_SLL;
                    6'h02:   ALUCtrl = ALU_SRL;
                    default: begin
                        // Unsupported funct is dropped without a write-back or retire.
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUCtrl  = ALU_SUB;
                PCSource = 2'b01;
                pc_we    = Zero;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                pc_we    = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUCtrl = ALU_ADD;
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - self-checking bench for mips_mc_ctrl
module tb_mips_mc_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        Zero;
    logic        mem_ready;
    logic [3:0]  ALUCtrl;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        RegWrite;
    logic [1:0]  PCSource;
    logic        pc_we;
    logic        illegal;
    logic [31:0] retired;

    mips_mc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .ALUCtrl   (ALUCtrl),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .PCSource  (PCSource),
        .pc_we     (pc_we),
        .illegal   (illegal),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cycles;
        logic       chk2;
        logic [3:0] alu2;
        logic       pcwe2;
        logic [1:0] pcs2;
        int         ill;
        int         rw;
        int         inc;
    } vec_t;

    typedef struct {
        string       name;
        int          cycles;
        logic        chk2;
        logic [3:0]  alu2;
        logic        pcwe2;
        logic [1:0]  pcs2;
        int          ill;
        int          rw;
        logic [31:0] ret;
    } exp_t;

    vec_t        vecs [15];
    exp_t        sb [$];
    logic [31:0] ret_model;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_fetch();
        return MemRead && !IorD && (ALUSrcB == 2'b01);
    endfunction

    // Runs one instruction from a sampled FETCH cycle until the next FETCH cycle.
    task automatic run_vec(input vec_t v);
        exp_t        e;
        int          c;
        int          ill_n;
        int          rw_n;
        logic [3:0]  alu_g;
        logic        pcwe_g;
        logic [1:0]  pcs_g;
        logic        done;
        ret_model = ret_model + v.inc;
        e.name = v.name; e.cycles = v.cycles; e.chk2 = v.chk2; e.alu2 = v.alu2;
        e.pcwe2 = v.pcwe2; e.pcs2 = v.pcs2; e.ill = v.ill; e.rw = v.rw; e.ret = ret_model;
        sb.push_back(e);
        opcode = v.op; funct = v.fn; Zero = v.z; mem_ready = 1'b1;
        #1;
        c = 0; ill_n = 0; rw_n = 0; alu_g = 4'hx; pcwe_g = 1'bx; pcs_g = 2'bxx; done = 1'b0;
        while (!done) begin
            if (c > 0 && is_fetch()) begin
                done = 1'b1;
            end else begin
                if (illegal) ill_n++;
                if (RegWrite) rw_n++;
                if (c == 2) begin
                    alu_g = ALUCtrl; pcwe_g = pc_we; pcs_g = PCSource;
                end
                if (c >= 40) begin
                    chk({v.name, " timeout"}, 32'(c), 32'(v.cycles));
                    done = 1'b1;
                end else begin
                    @(negedge clk); #1;
                    c++;
                end
            end
        end
        e = sb.pop_front();
        chk({e.name, " cycles"}, 32'(c), 32'(e.cycles));
        chk({e.name, " illegal pulses"}, 32'(ill_n), 32'(e.ill));
        chk({e.name, " regwrite cycles"}, 32'(rw_n), 32'(e.rw));
        chk({e.name, " retired"}, retired, e.ret);
        if (e.chk2) begin
            chk({e.name, " ALUCtrl c2"}, 32'(alu_g), 32'(e.alu2));
            chk({e.name, " pc_we c2"}, 32'(pcwe_g), 32'(e.pcwe2));
            chk({e.name, " PCSource c2"}, 32'(pcs_g), 32'(e.pcs2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{"sub",   6'h00, 6'h22, 1'b0, 4, 1'b1, 4'b0110, 1'b0, 2'b00, 0, 1, 1};
        vecs[1]  = '{"add",   6'h00, 6'h20, 1'b0, 4, 1'b1, 4'b0010, 1'b0, 2'b00, 0, 1, 1};
        vecs[2]  = '{"and",   6'h00, 6'h24, 1'b0, 4, 1'b1, 4'b0000, 1'b0, 2'b00, 0, 1, 1};
        vecs[3]  = '{"or",    6'h00, 6'h25, 1'b0, 4, 1'b1, 4'b0001, 1'b0, 2'b00, 0, 1, 1};
        vecs[4]  = '{"slt",   6'h00, 6'h2A, 1'b0, 4, 1'b1, 4'b0111, 1'b0, 2'b00, 0, 1, 1};
        vecs[5]  = '{"sll",   6'h00, 6'h00, 1'b0, 4, 1'b1, 4'b0100, 1'b0, 2'b00, 0, 1, 1};
        vecs[6]  = '{"srl",   6'h00, 6'h02, 1'b0, 4, 1'b1, 4'b0101, 1'b0, 2'b00, 0, 1, 1};
        vecs[7]  = '{"fn03",  6'h00, 6'h03, 1'b0, 3, 1'b0, 4'b0000, 1'b0, 2'b00, 1, 0, 0};
        vecs[8]  = '{"lw",    6'h23, 6'h11, 1'b0, 5, 1'b1, 4'b0010, 1'b0, 2'b00, 0, 1, 1};
        vecs[9]  = '{"sw",    6'h2B, 6'h11, 1'b0, 4, 1'b1, 4'b0010, 1'b0, 2'b00, 0, 0, 1};
        vecs[10] = '{"beq_z1",6'h04, 6'h00, 1'b1, 3, 1'b1, 4'b0110, 1'b1, 2'b01, 0, 0, 1};
        vecs[11] = '{"beq_z0",6'h04, 6'h00, 1'b0, 3, 1'b1, 4'b0110, 1'b0, 2'b01, 0, 0, 1};
        vecs[12] = '{"j",     6'h02, 6'h00, 1'b0, 3, 1'b1, 4'b0000, 1'b1, 2'b10, 0, 0, 1};
        vecs[13] = '{"addi",  6'h08, 6'h00, 1'b0, 4, 1'b1, 4'b0010, 1'b0, 2'b00, 0, 1, 1};
        vecs[14] = '{"op3f",  6'h3F, 6'h00, 1'b0, 2, 1'b0, 4'b0000, 1'b0, 2'b00, 1, 0, 0};

        rst_n = 1'b0; opcode = 6'h00; funct = 6'h22; Zero = 1'b0; mem_ready = 1'b1;
        ret_model = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset MemRead", 32'(MemRead), 32'd1);
        chk("reset ALUSrcB", 32'(ALUSrcB), 32'd1);
        chk("reset ALUCtrl", 32'(ALUCtrl), 32'b0010);
        chk("reset IRWrite", 32'(IRWrite), 32'd0);
        chk("reset pc_we", 32'(pc_we), 32'd0);
        chk("reset retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("fetch IRWrite", 32'(IRWrite), 32'd1);

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // lw with memory stalled three cycles in MEMRD
        opcode = 6'h23;
        for (int c = 0; c <= 8; c++) begin
            mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            if (c >= 3 && c <= 6) chk($sformatf("lw stall memrd c%0d", c), 32'(MemRead && IorD), 32'd1);
            chk($sformatf("lw stall RegWrite c%0d", c), 32'(RegWrite), (c == 7) ? 32'd1 : 32'd0);
            if (c == 7) chk("lw stall MemtoReg", 32'(MemtoReg), 32'd1);
            if (c == 8) begin
                ret_model = ret_model + 32'd1;
                chk("lw stall back to fetch", 32'(is_fetch()), 32'd1);
                chk("lw stall retired", retired, ret_model);
            end else begin
                @(negedge clk); #1;
            end
        end

        // reset asserted while sw waits in MEMWR
        opcode = 6'h2B; mem_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk); #1;
        chk("sw MemWrite before reset", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        ret_model = 32'd0;
        chk("sw reset MemWrite", 32'(MemWrite), 32'd0);
        chk("sw reset fetch decode", 32'(is_fetch()), 32'd1);
        chk("sw reset retired", retired, 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("sw reset IRWrite gated", 32'(IRWrite), 32'd0);
        chk("sw reset pc_we gated", 32'(pc_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_vec(vecs[0]);

        // retire counter wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        ret_model = 32'hFFFF_FFFF;
        chk("preload retired", retired, 32'hFFFF_FFFF);
        run_vec(vecs[12]);
        run_vec(vecs[12]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
